video_mode_sequencer: RTL



---
 rtl/video_mode_sequencer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/video_mode_sequencer.sv
// Runtime mode sequencer for the video timing generator: blanks, reloads timing fields under reset, then releases.
// Optional frame watchdog enabled by defining VIDEO_MODE_SEQ_WDOG_EN.
module video_mode_sequencer #(
   parameter logic [1:0]  DEFAULT_MODE   = 2'd1,
   parameter int unsigned BLANK_FRAMES   = 2,
   parameter int unsigned GEN_RST_CYCLES = 4,
   parameter int unsigned WDOG_CYCLES    = 2600000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [1:0]  req_mode,
   output logic        req_ready,
   input  logic        frame_start,
   output logic        gen_rst,
   output logic        blank,
   output logic [11:0] h_active,
   output logic [11:0] h_fporch,
   output logic [11:0] h_sync,
   output logic [11:0] h_bporch,
   output logic [10:0] v_active,
   output logic [10:0] v_fporch,
   output logic [10:0] v_sync,
   output logic [10:0] v_bporch,
   output logic [1:0]  cur_mode,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {ST_IDLE, ST_WAIT_EOF, ST_BLANK, ST_LOAD, ST_RESTART} state_t;

   typedef struct packed {
      logic [11:0] ha, hf, hs, hb;
      logic [10:0] va, vf, vs, vb;
   } timing_t;

   localparam logic [3:0] BLANK_N = 4'(BLANK_FRAMES);
   localparam logic [3:0] GEN_N   = 4'(GEN_RST_CYCLES);

   if (BLANK_FRAMES > 15 || GEN_RST_CYCLES < 1 || GEN_RST_CYCLES > 15 ||
       WDOG_CYCLES < 1 || WDOG_CYCLES > 4194303) begin : g_param_check
      $error("video_mode_sequencer: parameter out of range");
   end

   function automatic timing_t mode_row(input logic [1:0] mode);
      timing_t row;
      case (mode)
         2'd0: begin
            row.ha = 12'd1280; row.hf = 12'd110; row.hs = 12'd40; row.hb = 12'd220;
            row.va = 11'd720;  row.vf = 11'd5;   row.vs = 11'd5;  row.vb = 11'd20;
         end
         2'd2: begin
            row.ha = 12'd640;  row.hf = 12'd16;  row.hs = 12'd96; row.hb = 12'd48;
            row.va = 11'd480;  row.vf = 11'd10;  row.vs = 11'd2;  row.vb = 11'd33;
         end
         default: begin
            row.ha = 12'd1920; row.hf = 12'd88;  row.hs = 12'd44; row.hb = 12'd148;
            row.va = 11'd1080; row.vf = 11'd4;   row.vs = 11'd5;  row.vb = 11'd36;
         end
      endcase
      return row;
   endfunction

   state_t     state_r, state_s;
   logic [1:0] pend_mode_r, pend_mode_s;
   logic [3:0] frame_cnt_r, frame_cnt_s;
   logic [3:0] rst_cnt_r, rst_cnt_s;
   logic       req_ready_r, req_ready_s;
   logic       busy_r, busy_s;
   logic       blank_r, blank_s;
   logic       gen_rst_r, gen_rst_s;
   logic       err_r, err_s;
   logic [1:0] cur_mode_r, cur_mode_s;
   timing_t    timing_r, timing_s;
`ifdef VIDEO_MODE_SEQ_WDOG_EN
   localparam logic [21:0] WDOG_LAST = 22'(WDOG_CYCLES - 1);
   logic [21:0] wdog_cnt_r, wdog_cnt_s;
`endif

   // Next-state and next-output logic; every output is derived from the upcoming state.
   always_comb begin
      state_s     = state_r;
      pend_mode_s = pend_mode_r;
      frame_cnt_s = frame_cnt_r;
      rst_cnt_s   = rst_cnt_r;
      gen_rst_s   = gen_rst_r;
      err_s       = 1'b0;
      cur_mode_s  = cur_mode_r;
      timing_s    = timing_r;
      case (state_r)
         ST_IDLE: begin
            if (req_valid && req_ready_r) begin
               if (req_mode == 2'd3) begin
                  err_s = 1'b1;
               end else if (req_mode == cur_mode_r) begin
                  state_s = ST_IDLE;
               end else begin
                  pend_mode_s = req_mode;
                  state_s     = ST_WAIT_EOF;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT_EOF: begin
            if (frame_start) begin
               frame_cnt_s = 4'd0;
               state_s     = (BLANK_N == 4'd0) ? ST_LOAD : ST_BLANK;
            end else begin
               state_s = ST_WAIT_EOF;
            end
         end
         ST_BLANK: begin
            if (frame_start) begin
               frame_cnt_s = frame_cnt_r + 4'd1;
               state_s     = (frame_cnt_r + 4'd1 == BLANK_N) ? ST_LOAD : ST_BLANK;
            end else begin
               state_s = ST_BLANK;
            end
         end
         ST_LOAD: begin
            timing_s   = mode_row(pend_mode_r);
            cur_mode_s = pend_mode_r;
            gen_rst_s  = 1'b1;
            rst_cnt_s  = 4'd1;
            state_s    = ST_RESTART;
         end
         ST_RESTART: begin
            // rst_cnt_r counts the gen_rst cycles already spent, including the current one.
            if (gen_rst_r) begin
               if (rst_cnt_r >= GEN_N) begin
                  gen_rst_s = 1'b0;
               end else begin
                  rst_cnt_s = rst_cnt_r + 4'd1;
               end
            end else if (frame_start) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESTART;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            gen_rst_s = 1'b0;
         end
      endcase
`ifdef VIDEO_MODE_SEQ_WDOG_EN
      wdog_cnt_s = wdog_cnt_r + 22'd1;
      if ((state_r == ST_WAIT_EOF || state_r == ST_BLANK) && !frame_start &&
          wdog_cnt_r == WDOG_LAST) begin
         err_s   = 1'b1;
         state_s = ST_LOAD;
      end else if (state_r == ST_RESTART && !gen_rst_r && !frame_start &&
                   wdog_cnt_r == WDOG_LAST) begin
         err_s   = 1'b1;
         state_s = ST_IDLE;
      end else begin
         err_s = err_s;
      end
      // Counter only runs in the waiting states, and in RESTART only after gen_rst drops.
      if (state_s != state_r || frame_start || gen_rst_r ||
          state_r == ST_IDLE || state_r == ST_LOAD) begin
         wdog_cnt_s = 22'd0;
      end else begin
         wdog_cnt_s = wdog_cnt_s;
      end
`endif
      req_ready_s = (state_s == ST_IDLE);
      busy_s      = (state_s != ST_IDLE);
      blank_s     = (state_s != ST_IDLE);
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         pend_mode_r <= DEFAULT_MODE;
         frame_cnt_r <= 4'd0;
         rst_cnt_r   <= 4'd0;
         req_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         blank_r     <= 1'b0;
         gen_rst_r   <= 1'b0;
         err_r       <= 1'b0;
         cur_mode_r  <= DEFAULT_MODE;
         timing_r    <= mode_row(DEFAULT_MODE);
`ifdef VIDEO_MODE_SEQ_WDOG_EN
         wdog_cnt_r  <= 22'd0;
`endif
      end else begin
         state_r     <= state_s;
         pend_mode_r <= pend_mode_s;
         frame_cnt_r <= frame_cnt_s;
         rst_cnt_r   <= rst_cnt_s;
         req_ready_r <= req_ready_s;
         busy_r      <= busy_s;
         blank_r     <= blank_s;
         gen_rst_r   <= gen_rst_s;
         err_r       <= err_s;
         cur_mode_r  <= cur_mode_s;
         timing_r    <= timing_s;
`ifdef VIDEO_MODE_SEQ_WDOG_EN
         wdog_cnt_r  <= wdog_cnt_s;
`endif
      end
   end

   assign req_ready = req_ready_r;
   assign busy      = busy_r;
   assign blank     = blank_r;
   assign gen_rst   = gen_rst_r;
   assign err       = err_r;
   assign cur_mode  = cur_mode_r;
   assign h_active  = timing_r.ha;
   assign h_fporch  = timing_r.hf;
   assign h_sync    = timing_r.hs;
   assign h_bporch  = timing_r.hb;
   assign v_active  = timing_r.va;
   assign v_fporch  = timing_r.vf;
   assign v_sync    = timing_r.vs;
   assign v_bporch  = timing_r.vb;

endmodule
